// File: rtl/shift_pkg.sv
// ============================================================================
// shift_pkg : mode codes and helpers shared by the universal shift register
// Revision  : 1.0
// ============================================================================
`default_nettype none

package shift_pkg;

  localparam logic [2:0] M_HOLD = 3'd0;
  localparam logic [2:0] M_SHR  = 3'd1;
  localparam logic [2:0] M_SHL  = 3'd2;
  localparam logic [2:0] M_LOAD = 3'd3;
  localparam logic [2:0] M_ROR  = 3'd4;
  localparam logic [2:0] M_ROL  = 3'd5;
  localparam logic [2:0] M_ASR  = 3'd6;
  localparam logic [2:0] M_ZERO = 3'd7;

  // ceil(log2(width)) + 1, so the counter can hold any amount up to 2^n-1
  function automatic int cnt_width(input int width);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < width) w = i + 1;
    end
    return w + 1;
  endfunction

  // Only single-bit shift/rotate modes can be repeated by a burst
  function automatic logic is_burst_mode(input logic [2:0] m);
    return (m == M_SHR) || (m == M_SHL) || (m == M_ROR) ||
           (m == M_ROL) || (m == M_ASR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/shift_next_n.sv
// ============================================================================
// shift_next_n : combinational next-value function of the shift register
// Revision     : 1.0
// ============================================================================
`default_nettype none

module shift_next_n
  import shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] q,
  input  logic             sl,
  input  logic             sr,
  input  logic [WIDTH-1:0] pdata,
  output logic [WIDTH-1:0] q_next
);

  always_comb begin
    q_next = q;
    case (mode)
      M_HOLD: q_next = q;
      M_SHR:  q_next = {sr, q[WIDTH-1:1]};
      M_SHL:  q_next = {q[WIDTH-2:0], sl};
      M_LOAD: q_next = pdata;
      M_ROR:  q_next = {q[0], q[WIDTH-1:1]};
      M_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      M_ASR:  q_next = {q[WIDTH-1], q[WIDTH-1:1]};
      M_ZERO: q_next = '0;
      default: q_next = q;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/shift_reg_n.sv
// ============================================================================
// shift_reg_n : universal shift register with a counted burst-shift engine
// Revision    : 1.0
// ============================================================================
`default_nettype none

module shift_reg_n
  import shift_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [2:0]       mode,
  input  logic             SL,
  input  logic             SR,
  input  logic [WIDTH-1:0] PData,
  input  logic             start,
  input  logic [CNT_W-1:0] amount,
  output logic [WIDTH-1:0] Q,
  output logic             SO_L,
  output logic             SO_R,
  output logic             busy,
  output logic             done
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state;
  logic [0:0]       state_nx;
  logic [2:0]       lmode;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       eff_mode;
  logic [WIDTH-1:0] q_next;
  logic             burst_go;
  logic             zero_go;
  logic             last;

  // While a burst runs, the latched mode drives the datapath, not the live input
  assign eff_mode = (state == ST_RUN) ? lmode : mode;

  shift_next_n #(
    .WIDTH (WIDTH)
  ) u_next (
    .mode   (eff_mode),
    .q      (Q),
    .sl     (SL),
    .sr     (SR),
    .pdata  (PData),
    .q_next (q_next)
  );

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    burst_go = 1'b0;
    zero_go  = 1'b0;
    last     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && is_burst_mode(mode)) begin
          if (amount == '0) begin
            zero_go = 1'b1;
          end else begin
            burst_go = 1'b1;
            state_nx = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (cnt == CNT_W'(1)) begin
          last     = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_RUN);
  end

  // A zero-length burst still reports completion but leaves Q untouched
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      Q     <= '0;
      cnt   <= '0;
      lmode <= M_HOLD;
      done  <= 1'b0;
    end else begin
      done <= last | zero_go;
      if (state == ST_RUN) begin
        Q   <= q_next;
        cnt <= cnt - CNT_W'(1);
      end else if (burst_go) begin
        lmode <= mode;
        cnt   <= amount;
      end else if (!zero_go) begin
        Q <= q_next;
      end
    end
  end

  assign SO_L = Q[WIDTH-1];
  assign SO_R = Q[0];

endmodule

`default_nettype wire

// File: tb/tb_shift_reg_n.sv
// ============================================================================
// tb_shift_reg_n : directed self-checking bench for shift_reg_n (WIDTH=32)
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_shift_reg_n;

  localparam int WIDTH = 32;
  localparam int CNT_W = 6;

  localparam logic [2:0] HOLD = 3'd0;
  localparam logic [2:0] SHR  = 3'd1;
  localparam logic [2:0] SHL  = 3'd2;
  localparam logic [2:0] LOAD = 3'd3;
  localparam logic [2:0] ROR  = 3'd4;
  localparam logic [2:0] ROL  = 3'd5;
  localparam logic [2:0] ASR  = 3'd6;
  localparam logic [2:0] ZERO = 3'd7;

  logic             clk = 1'b0;
  logic             clear;
  logic [2:0]       mode;
  logic             SL;
  logic             SR;
  logic [WIDTH-1:0] PData;
  logic             start;
  logic [CNT_W-1:0] amount;
  logic [WIDTH-1:0] Q;
  logic             SO_L;
  logic             SO_R;
  logic             busy;
  logic             done;

  int checks   = 0;
  int failures = 0;

  shift_reg_n #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .clear  (clear),
    .mode   (mode),
    .SL     (SL),
    .SR     (SR),
    .PData  (PData),
    .start  (start),
    .amount (amount),
    .Q      (Q),
    .SO_L   (SO_L),
    .SO_R   (SO_R),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [WIDTH-1:0] value);
    mode  = LOAD;
    PData = value;
    start = 1'b0;
    step();
    mode  = HOLD;
  endtask

  // Clock until done is seen or the budget runs out; callers judge the count
  task automatic wait_done(input int limit, output int cycles);
    cycles = 0;
    while (!done && cycles < limit) begin
      step();
      cycles++;
    end
  endtask

  task automatic test_reset();
    clear  = 1'b0;
    mode   = 3'($urandom);
    SL     = 1'($urandom);
    SR     = 1'($urandom);
    PData  = $urandom;
    start  = 1'b1;
    amount = 6'($urandom_range(1, 63));
    repeat (3) step();
    checks++; if (Q !== 32'h0) begin failures++; $display("FAIL reset_q: got %h want %h", Q, 32'h0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
    @(negedge clk);
    mode  = LOAD;
    start = 1'b0;
    clear = 1'b1;
    #1;
    checks++; if (Q !== 32'h0) begin failures++; $display("FAIL reset_release_q: got %h want %h", Q, 32'h0); end
    PData = 32'hA5A5_A5A5;
    step();
    mode = HOLD;
    checks++; if (Q !== 32'hA5A5_A5A5) begin failures++; $display("FAIL first_load: got %h want %h", Q, 32'hA5A5_A5A5); end
    #2 clear = 1'b0;
    #1;
    checks++; if (Q !== 32'h0) begin failures++; $display("FAIL async_clear_q: got %h want %h", Q, 32'h0); end
    #1 clear = 1'b1;
  endtask

  task automatic test_shr();
    load(32'h8000_0000);
    mode = SHR;
    SR   = 1'b1;
    step();
    checks++; if (Q !== 32'hC000_0000) begin failures++; $display("FAIL shr_1: got %h want %h", Q, 32'hC000_0000); end
    repeat (29) step();
    checks++; if (SO_R !== 1'b0) begin failures++; $display("FAIL shr_so_r_30: got %b want 0", SO_R); end
    step();
    checks++; if (SO_R !== 1'b1) begin failures++; $display("FAIL shr_so_r_31: got %b want 1", SO_R); end
    step();
    checks++; if (Q !== 32'hFFFF_FFFF) begin failures++; $display("FAIL shr_32: got %h want %h", Q, 32'hFFFF_FFFF); end
    mode = HOLD;
  endtask

  task automatic test_shl();
    load(32'hAAAA_AAAA);
    mode = SHL;
    SL   = 1'b1;
    repeat (4) step();
    mode = HOLD;
    checks++; if (Q !== 32'hAAAA_AAAF) begin failures++; $display("FAIL shl_4: got %h want %h", Q, 32'hAAAA_AAAF); end
    checks++; if (SO_L !== 1'b1) begin failures++; $display("FAIL shl_so_l: got %b want 1", SO_L); end
  endtask

  task automatic test_burst_rol();
    int cycles;
    int nbusy;
    load(32'h1234_5678);
    mode   = ROL;
    amount = 6'd8;
    start  = 1'b1;
    step();
    start  = 1'b0;
    mode   = HOLD;
    amount = 6'd0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rol_busy_start: got %b want 1", busy); end
    checks++; if (Q !== 32'h1234_5678) begin failures++; $display("FAIL rol_accept_q: got %h want %h", Q, 32'h1234_5678); end
    cycles = 0;
    nbusy  = 1;
    while (!done && cycles < 20) begin
      if (cycles == 2) begin
        start  = 1'b1;
        mode   = LOAD;
        PData  = 32'h0;
        amount = 6'd5;
      end
      step();
      cycles++;
      start  = 1'b0;
      mode   = HOLD;
      amount = 6'd0;
      if (busy) nbusy++;
    end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL rol_done_timeout: got %b want 1", done); end
    checks++; if (cycles != 8) begin failures++; $display("FAIL rol_latency: got %0d want 8", cycles); end
    checks++; if (nbusy != 8) begin failures++; $display("FAIL rol_busy_cycles: got %0d want 8", nbusy); end
    checks++; if (Q !== 32'h3456_7812) begin failures++; $display("FAIL rol_result: got %h want %h", Q, 32'h3456_7812); end
    step();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rol_done_width: got %b want 0", done); end
    checks++; if (Q !== 32'h3456_7812) begin failures++; $display("FAIL rol_hold_after: got %h want %h", Q, 32'h3456_7812); end
  endtask

  task automatic test_back_to_back();
    int cycles;
    load(32'h8000_0000);
    mode   = ASR;
    amount = 6'd4;
    start  = 1'b1;
    step();
    start  = 1'b0;
    mode   = HOLD;
    wait_done(20, cycles);
    checks++; if (cycles != 4) begin failures++; $display("FAIL asr_latency: got %0d want 4", cycles); end
    checks++; if (Q !== 32'hF800_0000) begin failures++; $display("FAIL asr_result: got %h want %h", Q, 32'hF800_0000); end
    mode   = ROR;
    amount = 6'd40;
    start  = 1'b1;
    step();
    start  = 1'b0;
    mode   = HOLD;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ror_accept_in_done: got %b want 1", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL ror_done_cleared: got %b want 0", done); end
    wait_done(60, cycles);
    checks++; if (cycles != 40) begin failures++; $display("FAIL ror_latency: got %0d want 40", cycles); end
    // 40 rotates wrap to 8 positions on a 32-bit register
    checks++; if (Q !== 32'h00F8_0000) begin failures++; $display("FAIL ror40_result: got %h want %h", Q, 32'h00F8_0000); end
    step();
  endtask

  task automatic test_amount_zero();
    load(32'h0F0F_0F0F);
    mode   = SHR;
    amount = 6'd0;
    start  = 1'b1;
    step();
    start  = 1'b0;
    mode   = HOLD;
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL zero_amt_done: got %b want 1", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL zero_amt_busy: got %b want 0", busy); end
    checks++; if (Q !== 32'h0F0F_0F0F) begin failures++; $display("FAIL zero_amt_q: got %h want %h", Q, 32'h0F0F_0F0F); end
    step();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL zero_amt_done_clr: got %b want 0", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL zero_amt_busy2: got %b want 0", busy); end
  endtask

  task automatic test_start_nonshift();
    mode   = LOAD;
    PData  = 32'h1357_9BDF;
    amount = 6'd5;
    start  = 1'b1;
    step();
    checks++; if (Q !== 32'h1357_9BDF) begin failures++; $display("FAIL start_load_q: got %h want %h", Q, 32'h1357_9BDF); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL start_load_flags: got busy=%b done=%b want 0 0", busy, done); end
    mode = ZERO;
    step();
    start = 1'b0;
    mode  = HOLD;
    checks++; if (Q !== 32'h0) begin failures++; $display("FAIL start_zero_q: got %h want %h", Q, 32'h0); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL start_zero_flags: got busy=%b done=%b want 0 0", busy, done); end
  endtask

  task automatic test_reset_mid_burst();
    int  cycles;
    logic saw_done;
    load(32'hDEAD_BEEF);
    mode   = SHL;
    SL     = 1'b0;
    amount = 6'd10;
    start  = 1'b1;
    step();
    start  = 1'b0;
    mode   = HOLD;
    step();
    step();
    #2 clear = 1'b0;
    #1;
    checks++; if (Q !== 32'h0) begin failures++; $display("FAIL abort_q: got %h want %h", Q, 32'h0); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL abort_flags: got busy=%b done=%b want 0 0", busy, done); end
    #1 clear = 1'b1;
    saw_done = 1'b0;
    repeat (12) begin
      step();
      if (done) saw_done = 1'b1;
    end
    checks++; if (saw_done !== 1'b0) begin failures++; $display("FAIL abort_no_done: got %b want 0", saw_done); end
    load(32'h0000_0001);
    mode   = ROL;
    amount = 6'd3;
    start  = 1'b1;
    step();
    start  = 1'b0;
    mode   = HOLD;
    wait_done(10, cycles);
    checks++; if (cycles != 3) begin failures++; $display("FAIL post_abort_latency: got %0d want 3", cycles); end
    checks++; if (Q !== 32'h0000_0008) begin failures++; $display("FAIL post_abort_q: got %h want %h", Q, 32'h0000_0008); end
  endtask

  initial begin
    test_reset();
    test_shr();
    test_shl();
    test_burst_rol();
    test_back_to_back();
    test_amount_zero();
    test_start_nonshift();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
